// File: rtl/fifo_pkg.sv
// Shared constants and buffer-state encoding for the FIFO-to-stream reader.
// Latency: none (types and constants only). Backpressure: not applicable.
package fifo_pkg;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;
endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry ordered buffer; the head is always a register, never the push data.
// Latency: push visible at head 1 cycle later. Backpressure: caller must not push when full.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       held
);
    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    buf_state_t       state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   state <= (state == EMPTY) ? ONE : TWO;
                2'b01:   state <= (state == TWO) ? ONE : EMPTY;
                default: state <= state;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign held = state;
endmodule

// File: rtl/fifo_stream_reader.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream; FIFO_STREAM_READER_CNT_EN adds word_count.
// Latency: 2 cycles from fifo_empty falling to m_valid. Backpressure: reads stop once buffer plus in-flight reach 2.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    output logic [CNT_W-1:0] word_count
`endif
);
    logic       inflight;
    logic [1:0] held;
    logic       pop;
    logic [2:0] occ_after_pop;

    assign m_valid = rst_n && (held != 2'd0);
    assign pop     = m_valid && m_ready;

    // Counting the word leaving this cycle lets streaming sustain one read per cycle.
    assign occ_after_pop = {1'b0, held} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en    = rst_n && !fifo_empty && (occ_after_pop < 3'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_dat (fifo_data),
        .pop      (pop),
        .head     (m_data),
        .held     (held)
    );

`ifdef FIFO_STREAM_READER_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_count <= '0;
        end else if (pop) begin
            word_count <= word_count + 1'b1;
        end
    end
`endif
endmodule
